uart_tx_arbiter: RTL and testbench

- Shares a single UART serial transmit line between NUM_REQ byte requesters, arbitrated round-robin.
- Generates the baud timing and sequences the 12-bit frame: start, 8 data bits LSB first, even parity, 2 stop bits.
- Sits between on-chip byte producers and the serial pin.
- Replaces free-running, En-gated frame shifting with an explicit valid/ready handshake and a bit counter.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_baud_tick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the arbitrated UART transmitter: frame layout, FSM states, parity.
package uart_pkg;

  localparam int unsigned FRAME_BITS = 12;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned BIT_IDX_W  = 4;
  localparam logic        START_BIT  = 1'b0;
  localparam logic        STOP_BIT   = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Bit 0 (start) goes on the line first; the two stop bits are last.
  typedef struct packed {
    logic [1:0]        stop;
    logic              parity;
    logic [DATA_W-1:0] data;
    logic              start;
  } frame_t;

  function automatic logic even_parity(input logic [DATA_W-1:0] data);
    return ^data;
  endfunction

  function automatic frame_t build_frame(input logic [DATA_W-1:0] data);
    frame_t f;
    f.start  = START_BIT;
    f.data   = data;
    f.parity = even_parity(data);
    f.stop   = {STOP_BIT, STOP_BIT};
    return f;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-period counter: tick marks the last cycle of each bit, pre_tick the cycle before it.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PRE_CNT  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q <= '0;
    end else if (clear || (cnt_q == LAST_CNT)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick     = !clear && (cnt_q == LAST_CNT);
  assign pre_tick = !clear && (cnt_q == PRE_CNT);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX line among NUM_REQ byte requesters.
// Frame: start, 8 data bits LSB first, even parity, 2 stop bits.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int unsigned NUM_REQ      = 4,
  parameter  int unsigned CLKS_PER_BIT = 16,
  localparam int unsigned GNT_W        = $clog2(NUM_REQ)
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic [NUM_REQ-1:0]        Req_valid,
  input  logic [DATA_W*NUM_REQ-1:0] Req_data,
  output logic [NUM_REQ-1:0]        Req_ready,
  output logic                      Serial_op,
  output logic                      Busy,
  output logic [GNT_W-1:0]          Grant_id,
  output logic                      Frame_done
);

  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(FRAME_BITS - 1);
  localparam logic [GNT_W-1:0]     LAST_REQ = GNT_W'(NUM_REQ - 1);

  state_t                  state_q, state_d;
  logic [GNT_W-1:0]        ptr_q, ptr_d;
  logic [GNT_W-1:0]        gnt_q, gnt_d;
  logic [BIT_IDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic [FRAME_BITS-2:0]   rest_q, rest_d;
  logic                    serial_q, serial_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [DATA_W-1:0]       req_bytes [NUM_REQ];
  logic [GNT_W-1:0]        winner;
  logic [GNT_W-1:0]        ptr_after_win;
  logic                    found;
  frame_t                  win_frame;
  logic                    baud_clear;
  logic                    tick;
  logic                    pre_tick;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
    assign req_bytes[i] = Req_data[DATA_W*i +: DATA_W];
  end

  // First valid requester at or above the pointer, wrapping.
  always_comb begin
    int unsigned      idx;
    logic [GNT_W-1:0] cand;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    cand   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = GNT_W'(idx);
      if (!found && Req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    Req_ready = '0;
    if (Rst_n && (state_q == IDLE) && found) Req_ready[winner] = 1'b1;
  end

  assign ptr_after_win = (winner == LAST_REQ) ? '0 : winner + GNT_W'(1);
  assign win_frame     = build_frame(req_bytes[winner]);
  assign baud_clear    = (state_q == IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .clear    (baud_clear),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      bit_idx_q <= '0;
      rest_q    <= '0;
      serial_q  <= STOP_BIT;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      bit_idx_q <= bit_idx_d;
      rest_q    <= rest_d;
      serial_q  <= serial_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Accept captures the frame and drives the start bit; each baud wrap shifts the next bit out.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    bit_idx_d = bit_idx_q;
    rest_d    = rest_q;
    serial_d  = serial_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        serial_d = STOP_BIT;
        if (found) begin
          rest_d    = win_frame[FRAME_BITS-1:1];
          serial_d  = win_frame.start;
          gnt_d     = winner;
          ptr_d     = ptr_after_win;
          bit_idx_d = '0;
          busy_d    = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        // Registered so the pulse lands in the final cycle of the last stop bit.
        done_d = (bit_idx_q == LAST_BIT) && pre_tick;
        if (tick) begin
          if (bit_idx_q == LAST_BIT) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            serial_d = STOP_BIT;
          end else begin
            serial_d  = rest_q[0];
            rest_d    = {STOP_BIT, rest_q[FRAME_BITS-2:1]};
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Serial_op  = serial_q;
  assign Busy       = busy_q;
  assign Grant_id   = gnt_q;
  assign Frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with four requesters and 4 clocks per bit.
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned CPB       = 4;
  localparam int unsigned FRAME_CYC = 12 * CPB;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic [3:0]  Req_valid = '0;
  logic [31:0] Req_data = '0;
  logic [3:0]  Req_ready;
  logic        Serial_op;
  logic        Busy;
  logic [1:0]  Grant_id;
  logic        Frame_done;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 Clk = ~Clk;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Req_valid  (Req_valid),
    .Req_data   (Req_data),
    .Req_ready  (Req_ready),
    .Serial_op  (Serial_op),
    .Busy       (Busy),
    .Grant_id   (Grant_id),
    .Frame_done (Frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sample();
    @(negedge Clk);
    #1;
  endtask

  // Present a request in IDLE and check the combinational grant before the accept edge.
  task automatic start(input logic [3:0] v, input logic [31:0] d, input logic [3:0] exp_ready);
    sample();
    Req_valid = v;
    Req_data  = d;
    #1;
    check("accept_ready", 32'(Req_ready), 32'(exp_ready));
  endtask

  // Checks {Busy, Frame_done, Serial_op} on every cycle of a frame; f bit 0 goes out first.
  task automatic check_frame(input logic [11:0] f, input logic [1:0] gid, input bit drop);
    for (int i = 0; i < int'(FRAME_CYC); i++) begin
      sample();
      if (i == 0) begin
        check("grant_id", 32'(Grant_id), 32'(gid));
        check("ready_in_send", 32'(Req_ready), 32'h0);
        if (drop) begin
          Req_valid = '0;
          Req_data  = ~Req_data;
        end
      end
      check("frame", {29'h0, Busy, Frame_done, Serial_op},
            {29'h0, 1'b1, (i == int'(FRAME_CYC) - 1), f[i / int'(CPB)]});
    end
  endtask

  task automatic check_idle(input logic [3:0] exp_ready);
    sample();
    check("idle_line", {29'h0, Busy, Frame_done, Serial_op}, 32'h1);
    check("idle_ready", 32'(Req_ready), 32'(exp_ready));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    #2 Rst_n = 1'b0;
    #1;
    check("rst_serial", 32'(Serial_op), 32'h1);
    check("rst_busy", 32'(Busy), 32'h0);
    check("rst_done", 32'(Frame_done), 32'h0);
    check("rst_gid", 32'(Grant_id), 32'h0);
    check("rst_ready", 32'(Req_ready), 32'h0);
    repeat (2) sample();
    Rst_n = 1'b1;

    for (int i = 0; i < 100; i++) begin
      sample();
      check("idle100", {27'h0, Serial_op, Req_ready}, 32'h10);
    end

    // 0xA5: frame 0 | 1,0,1,0,0,1,0,1 | 0 | 1,1
    start(4'b0001, 32'h0000_00A5, 4'b0001);
    check_frame(12'hD4A, 2'd0, 1'b1);
    check_idle(4'b0000);

    // parity 1 for 0x07, parity 0 for 0x00 (pointer 1 -> scan wraps to 3)
    start(4'b1000, 32'h0700_0000, 4'b1000);
    check_frame(12'hE0E, 2'd3, 1'b1);
    check_idle(4'b0000);
    start(4'b1000, 32'h0000_0000, 4'b1000);
    check_frame(12'hC00, 2'd3, 1'b1);
    check_idle(4'b0000);

    // round robin with all valid held; one idle high cycle between frames
    start(4'b1111, 32'h8033_2211, 4'b0001);
    check_frame(12'hC22, 2'd0, 1'b0);
    check_idle(4'b0010);
    check_frame(12'hC44, 2'd1, 1'b0);
    check_idle(4'b0100);
    check_frame(12'hC66, 2'd2, 1'b0);
    check_idle(4'b1000);
    check_frame(12'hF00, 2'd3, 1'b0);
    check_idle(4'b0001);
    check_frame(12'hC22, 2'd0, 1'b1);
    check_idle(4'b0000);

    // pointer skip: serve 1, then 0011 -> 0; serve 1, then 0110 -> 2
    start(4'b0010, 32'h0000_2200, 4'b0010);
    check_frame(12'hC44, 2'd1, 1'b1);
    check_idle(4'b0000);
    start(4'b0011, 32'h0000_2211, 4'b0001);
    check_frame(12'hC22, 2'd0, 1'b1);
    check_idle(4'b0000);
    start(4'b0010, 32'h0000_2200, 4'b0010);
    check_frame(12'hC44, 2'd1, 1'b1);
    check_idle(4'b0000);
    start(4'b0110, 32'h0033_2200, 4'b0100);
    check_frame(12'hC66, 2'd2, 1'b1);
    check_idle(4'b0000);

    // reset during data bit 3 (frame bit 4) of 0xA5, request left asserted
    start(4'b0001, 32'h0000_00A5, 4'b0001);
    for (int i = 0; i < int'(4 * CPB + 2); i++) sample();
    check("mid_bit3", {30'h0, Busy, Serial_op}, 32'h2);
    #2 Rst_n = 1'b0;
    #1;
    check("mid_rst_serial", 32'(Serial_op), 32'h1);
    check("mid_rst_busy", 32'(Busy), 32'h0);
    check("mid_rst_gid", 32'(Grant_id), 32'h0);
    check("mid_rst_ready", 32'(Req_ready), 32'h0);
    sample();
    Req_valid = '0;
    Rst_n = 1'b1;
    start(4'b1000, 32'h0700_0000, 4'b1000);
    check_frame(12'hE0E, 2'd3, 1'b1);
    check_idle(4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
